// File: rtl/calendar_date_counter.sv
// Day/month/year BCD calendar that advances one day per tick.
// Also accepts a validated date-set request through a valid/ready handshake.
module calendar_date_counter #(
    parameter int          LEAP_MODE  = 1,
    parameter logic [15:0] RESET_YEAR = 16'h2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        set_valid,
    output logic        set_ready,
    input  logic [7:0]  set_day,
    input  logic [7:0]  set_mon,
    input  logic [15:0] set_year,
    output logic        set_err,
    output logic [7:0]  day_bcd,
    output logic [7:0]  mon_bcd,
    output logic [15:0] year_bcd,
    output logic [7:0]  dim_bcd,
    output logic        leap,
    output logic        new_month,
    output logic        new_year,
    output logic        year_wrap
);

    typedef enum logic {IDLE, CHECK} state_t;

    state_t state, state_nxt;

    logic [7:0]  cap_day, cap_mon;
    logic [15:0] cap_year;
    logic        pend;
    logic        apply;

    logic [7:0]  nxt_day, nxt_mon, nxt_dim;
    logic [15:0] nxt_year;
    logic        nxt_leap;
    logic        roll_m, roll_y, wrap;

    logic        cap_leap;
    logic [7:0]  cap_dim;
    logic        set_ok;

    // A two-digit BCD value 10T+U is divisible by 4 iff (2*T[0] + U) mod 4 == 0.
    function automatic logic div4(input logic [7:0] b);
        logic [1:0] s;
        s = {b[4], 1'b0} + b[1:0];
        return s == 2'b00;
    endfunction

    function automatic logic is_leap(input logic [15:0] y);
        if (LEAP_MODE == 0) return div4(y[7:0]);
        if (y[7:0] == 8'h00) return div4(y[15:8]);
        return div4(y[7:0]);
    endfunction

    function automatic logic [7:0] dim_of(input logic [7:0] m, input logic lp);
        logic [7:0] r;
        r = 8'h31;
        case (m)
            8'h02:                      r = lp ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
            default:                    r = 8'h31;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [15:0] bcd_inc16(input logic [15:0] y);
        logic [15:0] r;
        logic        c;
        r = y;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (y[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = y[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic nib_ok(input logic [31:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    assign set_ready = (state == IDLE);
    assign apply     = tick | pend;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (set_valid) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        roll_m   = (day_bcd == dim_bcd);
        roll_y   = roll_m && (mon_bcd == 8'h12);
        wrap     = roll_y && (year_bcd == 16'h9999);
        nxt_day  = bcd_inc8(day_bcd);
        nxt_mon  = mon_bcd;
        nxt_year = year_bcd;
        if (roll_m) begin
            nxt_day = 8'h01;
            if (roll_y) begin
                nxt_mon  = 8'h01;
                nxt_year = bcd_inc16(year_bcd);
            end else begin
                nxt_mon = bcd_inc8(mon_bcd);
            end
        end
        nxt_leap = is_leap(nxt_year);
        nxt_dim  = dim_of(nxt_mon, nxt_leap);
    end

    // Nibble check first so the numeric range compares are valid BCD compares.
    always_comb begin
        cap_leap = is_leap(cap_year);
        cap_dim  = dim_of(cap_mon, cap_leap);
        set_ok   = nib_ok({cap_day, cap_mon, cap_year})
                 && (cap_mon >= 8'h01) && (cap_mon <= 8'h12)
                 && (cap_day >= 8'h01) && (cap_day <= cap_dim);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            day_bcd   <= 8'h01;
            mon_bcd   <= 8'h01;
            year_bcd  <= RESET_YEAR;
            dim_bcd   <= 8'h31;
            leap      <= is_leap(RESET_YEAR);
            cap_day   <= 8'h00;
            cap_mon   <= 8'h00;
            cap_year  <= 16'h0000;
            pend      <= 1'b0;
            set_err   <= 1'b0;
            new_month <= 1'b0;
            new_year  <= 1'b0;
            year_wrap <= 1'b0;
        end else begin
            state     <= state_nxt;
            set_err   <= 1'b0;
            new_month <= 1'b0;
            new_year  <= 1'b0;
            year_wrap <= 1'b0;
            if (state == IDLE) begin
                pend <= 1'b0;
                if (set_valid) begin
                    cap_day  <= set_day;
                    cap_mon  <= set_mon;
                    cap_year <= set_year;
                end
                if (apply) begin
                    day_bcd   <= nxt_day;
                    mon_bcd   <= nxt_mon;
                    year_bcd  <= nxt_year;
                    dim_bcd   <= nxt_dim;
                    leap      <= nxt_leap;
                    new_month <= roll_m;
                    new_year  <= roll_y;
                    year_wrap <= wrap;
                end
            end else begin
                if (tick) pend <= 1'b1;
                if (set_ok) begin
                    day_bcd  <= cap_day;
                    mon_bcd  <= cap_mon;
                    year_bcd <= cap_year;
                    dim_bcd  <= cap_dim;
                    leap     <= cap_leap;
                end else begin
                    set_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed bench for calendar_date_counter; a second instance uses the
// simple %4 leap rule so both leap modes are exercised by the same stimulus.
module tb_calendar_date_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        set_valid = 1'b0;
    logic [7:0]  set_day = 8'h00;
    logic [7:0]  set_mon = 8'h00;
    logic [15:0] set_year = 16'h0000;

    logic        set_ready, set_err, leap, new_month, new_year, year_wrap;
    logic [7:0]  day_bcd, mon_bcd, dim_bcd;
    logic [15:0] year_bcd;

    logic        set_ready0, set_err0, leap0, new_month0, new_year0, year_wrap0;
    logic [7:0]  day_bcd0, mon_bcd0, dim_bcd0;
    logic [15:0] year_bcd0;

    int passed = 0;
    int total  = 0;

    logic [40:0] date_w, date0_w, exp_d;
    logic [3:0]  puls_w, exp_p;

    assign date_w  = {day_bcd, mon_bcd, year_bcd, dim_bcd, leap};
    assign date0_w = {day_bcd0, mon_bcd0, year_bcd0, dim_bcd0, leap0};
    assign puls_w  = {new_month, new_year, year_wrap, set_err};

    always #5 clk = ~clk;

    calendar_date_counter #(.LEAP_MODE(1), .RESET_YEAR(16'h2000)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .set_valid(set_valid), .set_ready(set_ready),
        .set_day(set_day), .set_mon(set_mon), .set_year(set_year),
        .set_err(set_err), .day_bcd(day_bcd), .mon_bcd(mon_bcd),
        .year_bcd(year_bcd), .dim_bcd(dim_bcd), .leap(leap),
        .new_month(new_month), .new_year(new_year), .year_wrap(year_wrap)
    );

    calendar_date_counter #(.LEAP_MODE(0), .RESET_YEAR(16'h2000)) dut0 (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .set_valid(set_valid), .set_ready(set_ready0),
        .set_day(set_day), .set_mon(set_mon), .set_year(set_year),
        .set_err(set_err0), .day_bcd(day_bcd0), .mon_bcd(mon_bcd0),
        .year_bcd(year_bcd0), .dim_bcd(dim_bcd0), .leap(leap0),
        .new_month(new_month0), .new_year(new_year0), .year_wrap(year_wrap0)
    );

    // Returns at the falling edge after the CHECK-exit edge.
    task automatic set_date(input logic [7:0] d, input logic [7:0] m,
                            input logic [15:0] y);
        @(negedge clk);
        set_valid = 1'b1;
        set_day   = d;
        set_mon   = m;
        set_year  = y;
        @(negedge clk);
        set_valid = 1'b0;
        @(negedge clk);
    endtask

    // Returns at the falling edge right after the updating edge.
    task automatic do_tick();
        repeat (2) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_d = {8'h01, 8'h01, 16'h2000, 8'h31, 1'b1};
        total++;
        if (date_w !== exp_d)
            $display("FAIL reset_date got %h exp %h", date_w, exp_d);
        else passed++;
        total++;
        if ({set_ready, puls_w} !== 5'b10000)
            $display("FAIL reset_ctl got %b exp 10000", {set_ready, puls_w});
        else passed++;
        total++;
        if (date0_w !== exp_d)
            $display("FAIL reset_date_m0 got %h exp %h", date0_w, exp_d);
        else passed++;
    endtask

    task automatic test_feb_2023();
        set_date(8'h28, 8'h02, 16'h2023);
        exp_d = {8'h28, 8'h02, 16'h2023, 8'h28, 1'b0};
        total++;
        if (date_w !== exp_d)
            $display("FAIL set_2023 got %h exp %h", date_w, exp_d);
        else passed++;
        do_tick();
        exp_d = {8'h01, 8'h03, 16'h2023, 8'h31, 1'b0};
        total++;
        if (date_w !== exp_d)
            $display("FAIL tick_2023 got %h exp %h", date_w, exp_d);
        else passed++;
        total++;
        if (puls_w !== 4'b1000)
            $display("FAIL pulse_2023 got %b exp 1000", puls_w);
        else passed++;
        @(negedge clk);
        total++;
        if (puls_w !== 4'b0000)
            $display("FAIL pulse_len got %b exp 0000", puls_w);
        else passed++;
    endtask

    task automatic test_leap_2024();
        set_date(8'h28, 8'h02, 16'h2024);
        do_tick();
        exp_d = {8'h29, 8'h02, 16'h2024, 8'h29, 1'b1};
        total++;
        if (date_w !== exp_d)
            $display("FAIL tick_feb28_2024 got %h exp %h", date_w, exp_d);
        else passed++;
        total++;
        if (puls_w !== 4'b0000)
            $display("FAIL pulse_feb29 got %b exp 0000", puls_w);
        else passed++;
        do_tick();
        exp_d = {8'h01, 8'h03, 16'h2024, 8'h31, 1'b1};
        total++;
        if (date_w !== exp_d)
            $display("FAIL tick_feb29_2024 got %h exp %h", date_w, exp_d);
        else passed++;
    endtask

    task automatic test_century();
        set_date(8'h28, 8'h02, 16'h2100);
        do_tick();
        exp_d = {8'h01, 8'h03, 16'h2100, 8'h31, 1'b0};
        total++;
        if (date_w !== exp_d)
            $display("FAIL greg_2100 got %h exp %h", date_w, exp_d);
        else passed++;
        exp_d = {8'h29, 8'h02, 16'h2100, 8'h29, 1'b1};
        total++;
        if (date0_w !== exp_d)
            $display("FAIL mod4_2100 got %h exp %h", date0_w, exp_d);
        else passed++;
        set_date(8'h15, 8'h02, 16'h2000);
        exp_d = {8'h15, 8'h02, 16'h2000, 8'h29, 1'b1};
        total++;
        if (date_w !== exp_d)
            $display("FAIL greg_2000 got %h exp %h", date_w, exp_d);
        else passed++;
    endtask

    task automatic test_bcd_inc();
        logic [7:0] dv [3];
        logic [7:0] ev [3];
        dv = '{8'h09, 8'h19, 8'h29};
        ev = '{8'h10, 8'h20, 8'h30};
        for (int i = 0; i < 3; i++) begin
            set_date(dv[i], 8'h07, 16'h2024);
            do_tick();
            exp_d = {ev[i], 8'h07, 16'h2024, 8'h31, 1'b1};
            total++;
            if (date_w !== exp_d)
                $display("FAIL bcd_inc_%0d got %h exp %h", i, date_w, exp_d);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        set_date(8'h31, 8'h12, 16'h9999);
        do_tick();
        exp_d = {8'h01, 8'h01, 16'h0000, 8'h31, 1'b1};
        total++;
        if (date_w !== exp_d)
            $display("FAIL wrap_date got %h exp %h", date_w, exp_d);
        else passed++;
        total++;
        if (puls_w !== 4'b1110)
            $display("FAIL wrap_pulses got %b exp 1110", puls_w);
        else passed++;
        set_date(8'h31, 8'h12, 16'h2024);
        do_tick();
        total++;
        if (puls_w !== 4'b1100)
            $display("FAIL year_pulses got %b exp 1100", puls_w);
        else passed++;
    endtask

    task automatic test_reject();
        logic [31:0] bad [6];
        bad = '{{8'h31, 8'h04, 16'h2024}, {8'h29, 8'h02, 16'h2023},
                {8'h00, 8'h05, 16'h2024}, {8'h01, 8'h13, 16'h2024},
                {8'h0A, 8'h05, 16'h2024}, {8'h01, 8'h05, 16'h20A4}};
        set_date(8'h10, 8'h10, 16'h2024);
        exp_d = {8'h10, 8'h10, 16'h2024, 8'h31, 1'b1};
        for (int i = 0; i < 6; i++) begin
            set_date(bad[i][31:24], bad[i][23:16], bad[i][15:0]);
            total++;
            if (date_w !== exp_d || puls_w !== 4'b0001)
                $display("FAIL reject_%0d got %h/%b exp %h/0001",
                         i, date_w, puls_w, exp_d);
            else passed++;
            @(negedge clk);
            total++;
            if (set_err !== 1'b0)
                $display("FAIL reject_len_%0d got %b exp 0", i, set_err);
            else passed++;
        end
    endtask

    task automatic test_tick_in_check();
        @(negedge clk);
        set_valid = 1'b1;
        set_day   = 8'h15;
        set_mon   = 8'h06;
        set_year  = 16'h2024;
        @(negedge clk);
        set_valid = 1'b0;
        tick      = 1'b1;
        total++;
        if (set_ready !== 1'b0)
            $display("FAIL ready_in_check got %b exp 0", set_ready);
        else passed++;
        @(negedge clk);
        tick = 1'b0;
        exp_d = {8'h15, 8'h06, 16'h2024, 8'h30, 1'b1};
        total++;
        if (date_w !== exp_d)
            $display("FAIL pend_n1 got %h exp %h", date_w, exp_d);
        else passed++;
        @(negedge clk);
        exp_d = {8'h16, 8'h06, 16'h2024, 8'h30, 1'b1};
        total++;
        if (date_w !== exp_d)
            $display("FAIL pend_n2 got %h exp %h", date_w, exp_d);
        else passed++;
    endtask

    task automatic test_back_to_back();
        repeat (2) @(negedge clk);
        set_valid = 1'b1;
        tick      = 1'b1;
        set_day   = 8'h01;
        set_mon   = 8'h01;
        set_year  = 16'h2025;
        @(negedge clk);
        set_valid = 1'b0;
        tick      = 1'b0;
        exp_d = {8'h17, 8'h06, 16'h2024, 8'h30, 1'b1};
        total++;
        if (date_w !== exp_d)
            $display("FAIL same_cycle_tick got %h exp %h", date_w, exp_d);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        exp_d = {8'h01, 8'h01, 16'h2025, 8'h31, 1'b0};
        total++;
        if (date_w !== exp_d)
            $display("FAIL same_cycle_set got %h exp %h", date_w, exp_d);
        else passed++;
    endtask

    task automatic test_reset_mid_check();
        @(negedge clk);
        set_valid = 1'b1;
        set_day   = 8'h15;
        set_mon   = 8'h06;
        set_year  = 16'h2024;
        @(negedge clk);
        set_valid = 1'b0;
        rst_n     = 1'b0;
        #2;
        exp_d = {8'h01, 8'h01, 16'h2000, 8'h31, 1'b1};
        total++;
        if (date_w !== exp_d)
            $display("FAIL async_reset got %h exp %h", date_w, exp_d);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (date_w !== exp_d || {set_ready, puls_w} !== 5'b10000)
            $display("FAIL reset_check got %h/%b exp %h/10000",
                     date_w, {set_ready, puls_w}, exp_d);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_feb_2023();
        test_leap_2024();
        test_century();
        test_bcd_inc();
        test_wrap();
        test_reject();
        test_tick_in_check();
        test_back_to_back();
        test_reset_mid_check();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
